// File: rtl/reg_scoreboard_if.sv
// Decode, writeback and squash bundle between the pipeline and the register hazard scoreboard.
interface reg_scoreboard_if #(
   parameter int NUM_REGS = 8,
   parameter int PERF_W   = 16
);
   localparam int SEL_W = $clog2(NUM_REGS);

   logic                id_valid;
   logic [SEL_W-1:0]    id_rs1_sel;
   logic                id_rs1_used;
   logic [SEL_W-1:0]    id_rs2_sel;
   logic                id_rs2_used;
   logic [SEL_W-1:0]    id_rd_sel;
   logic                id_rd_wr;
   logic                wb_en;
   logic [SEL_W-1:0]    wb_sel;
   logic                kill_en;
   logic [SEL_W-1:0]    kill_sel;

   logic                id_stall;
   logic                issue;
   logic [NUM_REGS-1:0] busy;
   logic [PERF_W-1:0]   stall_cycles;
   logic                err;

   modport master (
      output id_valid, id_rs1_sel, id_rs1_used, id_rs2_sel, id_rs2_used,
             id_rd_sel, id_rd_wr, wb_en, wb_sel, kill_en, kill_sel,
      input  id_stall, issue, busy, stall_cycles, err
   );

   modport slave (
      input  id_valid, id_rs1_sel, id_rs1_used, id_rs2_sel, id_rs2_used,
             id_rd_sel, id_rd_wr, wb_en, wb_sel, kill_en, kill_sel,
      output id_stall, issue, busy, stall_cycles, err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Decode-stage hazard scoreboard: per-register pending-write counters that stall decode on RAW
// hazards and on a full WAW window, plus a saturating stall counter and a sticky error flag.
module reg_scoreboard #(
   parameter int NUM_REGS = 8,
   parameter int CNT_W    = 2,
   parameter int PERF_W   = 16
) (
   input logic             clk,
   input logic             rst,
   reg_scoreboard_if.slave sb
);
   localparam int SEL_W = $clog2(NUM_REGS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]    cnt      [NUM_REGS];
   logic [CNT_W-1:0]    cnt_next [NUM_REGS];
   logic [CNT_W+1:0]    sum;
   logic [NUM_REGS-1:0] busy_vec;
   logic [NUM_REGS-1:0] inc;
   logic [NUM_REGS-1:0] decw;
   logic [NUM_REGS-1:0] deck;
   logic [NUM_REGS-1:0] under;
   logic                raw_hazard;
   logic                waw_hazard;
   logic                stall;
   logic                do_issue;
   logic                input_x;
   logic [PERF_W-1:0]   stall_cnt;
   logic                err_q;

   always_comb begin
      busy_vec = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         busy_vec[i] = (cnt[i] != '0);
      end
   end

   // Stall is judged only on registered state, so a writeback landing this cycle does not release it.
   always_comb begin
      raw_hazard = (sb.id_rs1_used && busy_vec[sb.id_rs1_sel]) ||
                   (sb.id_rs2_used && busy_vec[sb.id_rs2_sel]);
      waw_hazard = sb.id_rd_wr && (cnt[sb.id_rd_sel] == CNT_MAX);
      stall      = sb.id_valid && (raw_hazard || waw_hazard);
      do_issue   = sb.id_valid && !stall;
   end

   // Negative results show up in the top bit of the widened sum and are clamped to zero.
   always_comb begin
      inc   = '0;
      decw  = '0;
      deck  = '0;
      under = '0;
      sum   = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_next[i] = cnt[i];
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         inc[i]  = do_issue && sb.id_rd_wr && (sb.id_rd_sel == SEL_W'(i));
         decw[i] = sb.wb_en && (sb.wb_sel == SEL_W'(i));
         deck[i] = sb.kill_en && (sb.kill_sel == SEL_W'(i));
         sum     = {2'b00, cnt[i]}
                 + {{(CNT_W+1){1'b0}}, inc[i]}
                 - {{(CNT_W+1){1'b0}}, decw[i]}
                 - {{(CNT_W+1){1'b0}}, deck[i]};
         if (sum[CNT_W+1]) begin
            under[i]    = 1'b1;
            cnt_next[i] = '0;
         end else begin
            cnt_next[i] = sum[CNT_W-1:0];
         end
      end
   end

   always_comb begin
      input_x = ((^{sb.id_valid, sb.id_rs1_sel, sb.id_rs1_used, sb.id_rs2_sel,
                    sb.id_rs2_used, sb.id_rd_sel, sb.id_rd_wr, sb.wb_en, sb.wb_sel,
                    sb.kill_en, sb.kill_sel}) === 1'bx);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt[i] <= '0;
         end
         stall_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt[i] <= cnt_next[i];
         end
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
         end
         if ((|under) || input_x) begin
            err_q <= 1'b1;
         end
      end
   end

   assign sb.id_stall     = stall;
   assign sb.issue        = do_issue;
   assign sb.busy         = busy_vec;
   assign sb.stall_cycles = stall_cnt;
   assign sb.err          = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: integer pending-count model checked every cycle,
// directed hazard scenarios with literal expectations, and a randomized traffic phase.
module tb_reg_scoreboard;
   localparam int NR   = 8;
   localparam int PW   = 16;
   localparam int CMAX = 3;
   localparam int PMAX = 65535;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_scoreboard_if #(.NUM_REGS(NR), .PERF_W(PW)) sbif ();

   reg_scoreboard #(.NUM_REGS(NR), .CNT_W(2), .PERF_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sbif)
   );

   int checks = 0;
   int errors = 0;
   int pend [NR];
   bit m_err;
   int m_stall;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   // Inputs change just after the rising edge; combinational outputs are settled on return.
   task automatic applyStimulus(input logic v, input logic [2:0] r1, input logic u1,
                                input logic [2:0] r2, input logic u2,
                                input logic [2:0] rd, input logic wr,
                                input logic wb, input logic [2:0] wbs,
                                input logic kl, input logic [2:0] kls);
      @(posedge clk);
      #1;
      sbif.id_valid    = v;
      sbif.id_rs1_sel  = r1;
      sbif.id_rs1_used = u1;
      sbif.id_rs2_sel  = r2;
      sbif.id_rs2_used = u2;
      sbif.id_rd_sel   = rd;
      sbif.id_rd_wr    = wr;
      sbif.wb_en       = wb;
      sbif.wb_sel      = wbs;
      sbif.kill_en     = kl;
      sbif.kill_sel    = kls;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // The model holds one integer of in-flight writes per register; stall and issue follow from it.
   task automatic modelStep();
      logic [NR-1:0] exp_busy;
      bit es;
      bit ei;
      int n;
      if (!rst) begin
         foreach (pend[i]) pend[i] = 0;
         m_err   = 0;
         m_stall = 0;
      end
      exp_busy = '0;
      foreach (pend[i]) exp_busy[i] = (pend[i] > 0);
      es = sbif.id_valid &&
           ((sbif.id_rs1_used && pend[sbif.id_rs1_sel] > 0) ||
            (sbif.id_rs2_used && pend[sbif.id_rs2_sel] > 0) ||
            (sbif.id_rd_wr && pend[sbif.id_rd_sel] == CMAX));
      ei = sbif.id_valid && !es;
      checkOutput("model_stall", 32'(sbif.id_stall), 32'(es));
      checkOutput("model_issue", 32'(sbif.issue), 32'(ei));
      checkOutput("model_busy", 32'(sbif.busy), 32'(exp_busy));
      checkOutput("model_stall_cycles", 32'(sbif.stall_cycles), 32'(m_stall));
      checkOutput("model_err", 32'(sbif.err), 32'(m_err));
      if (rst) begin
         if ((^{sbif.id_valid, sbif.id_rs1_sel, sbif.id_rs1_used, sbif.id_rs2_sel,
                sbif.id_rs2_used, sbif.id_rd_sel, sbif.id_rd_wr, sbif.wb_en, sbif.wb_sel,
                sbif.kill_en, sbif.kill_sel}) === 1'bx)
            m_err = 1;
         for (int i = 0; i < NR; i++) begin
            n = pend[i];
            if (ei && sbif.id_rd_wr && sbif.id_rd_sel == 3'(i)) n = n + 1;
            if (sbif.wb_en && sbif.wb_sel == 3'(i)) n = n - 1;
            if (sbif.kill_en && sbif.kill_sel == 3'(i)) n = n - 1;
            if (n < 0) begin
               n = 0;
               m_err = 1;
            end
            pend[i] = n;
         end
         if (es && m_stall < PMAX) m_stall++;
      end
   endtask

   task automatic compareLoop();
      forever begin
         @(negedge clk);
         modelStep();
      end
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      logic [2:0] s;
      logic [2:0] k;
      logic w;
      logic kl;
      logic [2:0] xsel;
      sbif.id_valid = 0; sbif.id_rs1_sel = 0; sbif.id_rs1_used = 0;
      sbif.id_rs2_sel = 0; sbif.id_rs2_used = 0; sbif.id_rd_sel = 0; sbif.id_rd_wr = 0;
      sbif.wb_en = 0; sbif.wb_sel = 0; sbif.kill_en = 0; sbif.kill_sel = 0;
      foreach (pend[i]) pend[i] = 0;
      m_err = 0;
      m_stall = 0;
      fork
         compareLoop();
      join_none
      #1 rst = 1'b0;
      #2;
      checkOutput("reset_busy", 32'(sbif.busy), 32'h0);
      checkOutput("reset_err", 32'(sbif.err), 32'h0);
      checkOutput("reset_stall_cycles", 32'(sbif.stall_cycles), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;

      // RAW hazard on R2, released the cycle after its writeback.
      applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
      checkOutput("raw_first_issue", 32'(sbif.issue), 32'h1);
      applyStimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("raw_stall", 32'(sbif.id_stall), 32'h1);
      applyStimulus(1, 2, 1, 0, 0, 0, 0, 1, 2, 0, 0);
      checkOutput("raw_stall_during_wb", 32'(sbif.id_stall), 32'h1);
      applyStimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("raw_released", 32'(sbif.id_stall), 32'h0);
      checkOutput("raw_issue", 32'(sbif.issue), 32'h1);
      checkOutput("raw_stall_cycles", 32'(sbif.stall_cycles), 32'h2);

      // WAW window on R5 fills at three in-flight writes.
      repeat (3) begin
         applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
         checkOutput("waw_fill_issue", 32'(sbif.issue), 32'h1);
      end
      applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      checkOutput("waw_full_stall", 32'(sbif.id_stall), 32'h1);
      checkOutput("waw_full_issue", 32'(sbif.issue), 32'h0);
      applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 5, 0, 0);
      checkOutput("waw_wb_same_cycle", 32'(sbif.id_stall), 32'h1);
      applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      checkOutput("waw_after_wb_issue", 32'(sbif.issue), 32'h1);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
      idle();
      checkOutput("waw_drained", 32'(sbif.busy), 32'h0);

      // Simultaneous inc/dec on R1, then writeback and squash together.
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
      checkOutput("simul_issue", 32'(sbif.issue), 32'h1);
      idle();
      checkOutput("simul_busy1", 32'(sbif.busy[1]), 32'h1);
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
      idle();
      checkOutput("wb_kill_clear", 32'(sbif.busy[1]), 32'h0);
      checkOutput("wb_kill_no_err", 32'(sbif.err), 32'h0);

      // Underflow on idle R6 is clamped and flagged.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
      checkOutput("under_pre_edge", 32'(sbif.err), 32'h0);
      idle();
      checkOutput("under_err", 32'(sbif.err), 32'h1);
      checkOutput("under_busy", 32'(sbif.busy), 32'h0);
      repeat (3) idle();
      checkOutput("err_sticky", 32'(sbif.err), 32'h1);

      // Asynchronous reset in the middle of a cycle with R3 holding two writes.
      applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
      idle();
      checkOutput("pre_reset_busy", 32'(sbif.busy), 32'h08);
      #1 rst = 1'b0;
      #1;
      checkOutput("async_busy", 32'(sbif.busy), 32'h0);
      checkOutput("async_err", 32'(sbif.err), 32'h0);
      checkOutput("async_stall_cycles", 32'(sbif.stall_cycles), 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      idle();
      checkOutput("post_reset_busy", 32'(sbif.busy), 32'h0);

      // Randomized traffic, writebacks biased toward registers that are actually pending.
      for (int c = 0; c < 1500; c++) begin
         s = 3'($urandom_range(0, 7));
         k = 3'($urandom_range(0, 7));
         w  = (pend[s] > 0) ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 199) == 0);
         kl = (pend[k] > 0) ? ($urandom_range(0, 99) < 10) : 1'b0;
         applyStimulus($urandom_range(0, 9) < 7, 3'($urandom), $urandom_range(0, 1) == 1,
                       3'($urandom), $urandom_range(0, 1) == 1,
                       3'($urandom), $urandom_range(0, 9) < 6, w, s, kl, k);
         if (c == 750) pulseReset();
      end

      // Long RAW stall drives the performance counter into saturation.
      pulseReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int c = 0; c < 65540; c++) begin
         applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      idle();
      checkOutput("stall_saturated", 32'(sbif.stall_cycles), 32'hFFFF);

      // Unknown writeback select with no writeback enabled.
      xsel = 3'bx;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, xsel, 0, 0);
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
